// File: rtl/trigger_queue_data_inf_c.sv
// -----------------------------------------------------------------------------
// trigger_queue_data_inf_c
//
// Multi-channel trigger-to-stream converter. Each channel captures its data
// word on a trigger strobe into a one-deep pending slot. A round-robin arbiter
// moves pending words, one per cycle, into a shared show-ahead FIFO. The FIFO
// head is presented as a valid/ready stream tagged with the source channel.
// Triggers that hit an occupied, non-granted slot are counted as overflows.
//
// Ports:
//   clock       clock
//   rst_n       asynchronous active-low reset
//   trigger     per-channel capture strobe (bit i = channel i)
//   data        channel i word at [i*DSIZE +: DSIZE], sampled on trigger[i]
//   out_valid   FIFO head valid
//   out_ready   consumer accept
//   out_data    FIFO head data
//   out_chan    source channel of the head word
//   fifo_count  FIFO occupancy
//   overflow    sticky per-channel pending-slot overflow flags
//   drop_cnt    saturating count of dropped/overwritten words
//   clr_stat    pulse: clears overflow and drop_cnt
// -----------------------------------------------------------------------------
module trigger_queue_data_inf_c #(
    parameter int DSIZE    = 32,
    parameter int NCH      = 4,
    parameter int DEPTH    = 8,
    parameter int OVW_MODE = 0,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CNTW    = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       trigger,
    input  logic [NCH*DSIZE-1:0] data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DSIZE-1:0]     out_data,
    output logic [CW-1:0]        out_chan,
    output logic [CNTW-1:0]      fifo_count,
    output logic [NCH-1:0]       overflow,
    output logic [15:0]          drop_cnt,
    input  logic                 clr_stat
);

    localparam int EW = CW + DSIZE;

    // Number of overflow events in one cycle (at most NCH <= 16).
    function automatic logic [4:0] popcnt(input logic [NCH-1:0] v);
        logic [4:0] s;
        s = 5'd0;
        for (int i = 0; i < NCH; i++) begin
            s = s + {4'd0, v[i]};
        end
        return s;
    endfunction

    // Pending slots
    logic [NCH-1:0]   pend_vld_q, pend_vld_d;
    logic [DSIZE-1:0] pend_data_q [NCH];
    logic [DSIZE-1:0] pend_data_d [NCH];

    // Arbiter
    logic [CW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    scan_idx_s;
    logic             grant_vld_s;
    logic [CW-1:0]    grant_idx_s;
    logic [NCH-1:0]   grant_oh_s;
    logic             room_s;

    // FIFO
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             pop_s;

    // Statistics
    logic [NCH-1:0]   ev_s;
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic [15:0]      drop_q, drop_d;
    logic [15:0]      drop_base_s;
    logic [16:0]      drop_sum_s;

    // Output view of the FIFO head and status registers.
    always_comb begin
        out_valid  = (cnt_q != {CNTW{1'b0}});
        out_data   = mem_q[rd_q][DSIZE-1:0];
        out_chan   = mem_q[rd_q][EW-1:DSIZE];
        fifo_count = cnt_q;
        overflow   = ovf_q;
        drop_cnt   = drop_q;
    end

    // Round-robin arbiter. A full FIFO may still accept a word when the head
    // is popped in the same cycle, which is the only out_ready -> grant path.
    always_comb begin
        pop_s       = out_valid & out_ready;
        room_s      = (cnt_q < CNTW'(DEPTH)) | pop_s;
        grant_vld_s = 1'b0;
        grant_idx_s = {CW{1'b0}};
        scan_idx_s  = {CW{1'b0}};
        grant_oh_s  = {NCH{1'b0}};
        if (room_s) begin
            // Scan from farthest to nearest so the nearest requester wins.
            for (int k = NCH - 1; k >= 0; k--) begin
                scan_idx_s = CW'((int'(rr_q) + k) % NCH);
                if (pend_vld_q[scan_idx_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = scan_idx_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            grant_vld_s = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            grant_oh_s[i] = grant_vld_s & (grant_idx_s == CW'(i));
        end
        if (grant_vld_s) begin
            rr_d = CW'((int'(grant_idx_s) + 1) % NCH);
        end else begin
            rr_d = rr_q;
        end
    end

    // Pending-slot next state and overflow event detection.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pend_vld_d[i]  = pend_vld_q[i];
            pend_data_d[i] = pend_data_q[i];
            ev_s[i]        = 1'b0;
            if (trigger[i]) begin
                if (pend_vld_q[i] && !grant_oh_s[i]) begin
                    // Occupied slot that is not draining this cycle.
                    ev_s[i] = 1'b1;
                    if (OVW_MODE != 0) begin
                        pend_data_d[i] = data[i*DSIZE +: DSIZE];
                    end else begin
                        pend_data_d[i] = pend_data_q[i];
                    end
                end else begin
                    pend_vld_d[i]  = 1'b1;
                    pend_data_d[i] = data[i*DSIZE +: DSIZE];
                end
            end else if (grant_oh_s[i]) begin
                pend_vld_d[i] = 1'b0;
            end else begin
                pend_vld_d[i] = pend_vld_q[i];
            end
        end
    end

    // Statistics next state: the clear is applied first, then this cycle's events.
    always_comb begin
        if (clr_stat) begin
            ovf_d       = ev_s;
            drop_base_s = 16'd0;
        end else begin
            ovf_d       = ovf_q | ev_s;
            drop_base_s = drop_q;
        end
        drop_sum_s = {1'b0, drop_base_s} + {12'd0, popcnt(ev_s)};
        if (drop_sum_s[16]) begin
            drop_d = 16'hFFFF;
        end else begin
            drop_d = drop_sum_s[15:0];
        end
    end

    // FIFO occupancy next state.
    always_comb begin
        case ({grant_vld_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pending slots, arbiter pointer and statistics registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                pend_data_q[i] <= {DSIZE{1'b0}};
            end
            rr_q   <= {CW{1'b0}};
            ovf_q  <= {NCH{1'b0}};
            drop_q <= 16'd0;
        end else begin
            pend_vld_q <= pend_vld_d;
            for (int i = 0; i < NCH; i++) begin
                pend_data_q[i] <= pend_data_d[i];
            end
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // FIFO storage and pointers; storage is cleared so the head never shows X.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= {EW{1'b0}};
            end
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {CNTW{1'b0}};
        end else begin
            if (grant_vld_s) begin
                mem_q[wr_q] <= {grant_idx_s, pend_data_q[grant_idx_s]};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/trigger_queue_data_inf_c.md
# trigger_queue_data_inf_c

Multi-channel trigger-to-stream converter: each of NCH channels captures its data word on a trigger pulse, holds it in a one-deep pending slot, and a round-robin arbiter moves pending words into a shared show-ahead FIFO of depth DEPTH that drives a valid/ready output stream tagged with the source channel. It sits between event/strobe sources (timers, status edges, register writes) and data_inf_c-style stream consumers. Multi-channel capture, buffering and overflow accounting come from this block.

## Interface
- DSIZE, 32, data width per channel
- NCH, 4, number of trigger channels (1..16)
- DEPTH, 8, output FIFO depth, power of two, >= 2
- OVW_MODE, 0, pending-slot overflow policy: 0 = keep old word, drop new; 1 = overwrite with new word
- clock  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- trigger  input  NCH  per-channel capture strobe, bit i = channel i
- data  input  NCH*DSIZE  channel i data at bits [i*DSIZE +: DSIZE], sampled only on trigger[i]
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accept
- out_data  output  DSIZE  FIFO head data
- out_chan  output  max(1,$clog2(NCH))  source channel of head word
- fifo_count  output  $clog2(DEPTH+1)  FIFO occupancy
- overflow  output  NCH  sticky per-channel pending-slot overflow flag
- drop_cnt  output  16  total dropped/overwritten words, saturating at 16'hFFFF
- clr_stat  input  1  pulse: clears overflow and drop_cnt

## Operation
- Pending slot per channel: pend_vld[i], pend_data[i]. On trigger[i], pend_data[i] <= data slice i and pend_vld[i] <= 1.
- Trigger on channel with pend_vld[i]=1 and not granted this cycle: overflow event. OVW_MODE=0 keeps the old word; OVW_MODE=1 replaces it. Either way overflow[i] <= 1 and drop_cnt increments by 1 (saturating).
- Trigger on a channel granted the same cycle: the old word goes to the FIFO, the new word loads the slot. This is not an overflow.
- Simultaneous overflow events on k channels in one cycle: drop_cnt += k, saturating.
- Arbiter: rr_ptr resets to 0. It grants the first channel with pend_vld=1 searching upward from rr_ptr, wrapping modulo NCH. At most one grant per cycle. After a grant, rr_ptr <= grant+1 mod NCH; with no grant, rr_ptr holds.
- Grant allowed when fifo_count < DEPTH, or when fifo_count == DEPTH and a pop occurs this cycle (out_valid && out_ready).
- Granted slot: pend_vld cleared unless reloaded the same cycle. FIFO entry = {channel, pend_data}.
- FIFO: show-ahead. out_valid = (fifo_count != 0). out_data and out_chan are the head entry. Pop on out_valid && out_ready. Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- clr_stat: overflow and drop_cnt clear. Overflow events in the same cycle are applied after the clear: the flag is set and the count equals the events of that cycle.
- out_data/out_chan with out_valid=0: don't care, but no X after reset.

## Timing
- Reset (asynchronous): pend_vld=0, rr_ptr=0, FIFO empty, out_valid=0, fifo_count=0, out_data=0, out_chan=0, overflow=0, drop_cnt=0. Reset mid-operation discards all pending and queued words.
- Latency with idle arbiter and non-full FIFO: trigger in cycle t -> pend_vld in t+1 -> grant in t+1 -> out_valid in t+2. Two cycles.
- Throughput: one word per cycle into and out of the FIFO.
- out_valid and out_data remain stable while out_valid && !out_ready.
- All outputs are registered or derived from FIFO pointers/registers. There is no combinational path from trigger/data to any output.
- out_ready has a combinational path to grant, for the full-FIFO push-on-pop case only.

## Test plan
- Single word: NCH=4, trigger[2] for one cycle with channel-2 data 32'hA5A5_0002, out_ready=1 -> out_valid high two cycles later for exactly one cycle, out_data=32'hA5A5_0002, out_chan=2, fifo_count returns to 0.
- Round-robin: trigger=4'b1111 in one cycle with data i = 32'h100+i -> four output words in order chan 0,1,2,3. Next trigger=4'b1001 -> order chan 0,3 from rr_ptr=0 after wrap.
- Backpressure/full: DEPTH=8, out_ready=0, trigger[0] on 10 consecutive cycles with data 1..10, OVW_MODE=0 -> fifo_count=8 (words 1..8), slot holds 9, word 10 dropped, overflow=4'b0001, drop_cnt=1. Then out_ready=1 -> words 1..9 are output, with no bubble when the slot refills the FIFO.
- Overwrite mode: OVW_MODE=1, same stimulus -> words 1..8, then 10; drop_cnt=1.
- Grant-and-retrigger: with FIFO full, hold trigger[1] every cycle while popping one word per cycle -> each grant coincides with a reload, overflow stays 0, drop_cnt unchanged.
- Stats and reset: preload drop_cnt to 16'hFFFF via repeated overflows -> it saturates. clr_stat together with an overflow on channel 3 -> overflow=4'b1000, drop_cnt=1. Assert rst_n low with 5 words queued -> all outputs go to reset values immediately, and no stale word appears after release.
